cell_row_cfg: RTL and testbench

Parametrised successor to the fixed 4-bit-LUT cell row. It holds one row of DIMX K-input LUT cells with double-buffered configuration, so the row keeps evaluating its current genome while the next one streams in. Configuration arrives through a PORT_WIDTH-bit valid/ready stream with an internal slot counter, replacing external per-slot write enables. The block sits between the genome RAM reader and the evaluation array, one instance per array row.

---
 rtl/cell_row_cfg.sv | 86 ++++++++
 tb/tb_cell_row_cfg.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cell_row_cfg.sv
// One row of DIMX K-input LUT cells with double-buffered configuration.
// Config streams into shadow over a valid/ready port and is swapped into active on commit.
module cell_row_cfg #(
    parameter int DIMX       = 64,
    parameter int K          = 2,
    parameter int PORT_WIDTH = 32,
    localparam int LUT_BITS  = 1 << K,
    localparam int SLOTS     = DIMX * LUT_BITS / PORT_WIDTH,
    localparam int SW        = $clog2(SLOTS) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DIMX+K-2:0]     in_signal,
    input  logic                  eval_en,
    input  logic                  cfg_start,
    input  logic                  cfg_valid,
    input  logic [PORT_WIDTH-1:0] cfg_data,
    output logic                  cfg_ready,
    output logic                  cfg_done,
    output logic                  busy,
    output logic [SW-1:0]         slot_idx,
    output logic [DIMX-1:0]       out
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOAD   = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    logic [1:0]               state;
    logic [DIMX*LUT_BITS-1:0] shadow;
    logic [DIMX*LUT_BITS-1:0] active;
    logic [DIMX-1:0]          nxt;

    assign cfg_ready = (state == LOAD);
    assign busy      = (state != IDLE);

    for (genvar x = 0; x < DIMX; x++) begin : g_cell
        logic [LUT_BITS-1:0] lut;
        logic [K-1:0]        sel;
        assign lut    = active[x*LUT_BITS +: LUT_BITS];
        assign sel    = in_signal[x +: K];
        assign nxt[x] = lut[sel];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            slot_idx <= '0;
            shadow   <= '0;
            active   <= '0;
            out      <= '0;
            cfg_done <= 1'b0;
        end else begin
            cfg_done <= 1'b0;
            if (eval_en) out <= nxt;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        state    <= LOAD;
                        slot_idx <= '0;
                    end
                end
                LOAD: begin
                    // a restart discards whatever word is presented alongside it
                    if (cfg_start) begin
                        slot_idx <= '0;
                    end else if (cfg_valid) begin
                        for (int s = 0; s < SLOTS; s++) begin
                            if (slot_idx == SW'(s))
                                shadow[s*PORT_WIDTH +: PORT_WIDTH] <= cfg_data;
                        end
                        slot_idx <= slot_idx + SW'(1);
                        if (slot_idx == SW'(SLOTS - 1)) state <= COMMIT;
                    end
                end
                COMMIT: begin
                    active   <= shadow;
                    cfg_done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cell_row_cfg.sv
// Directed and table-driven bench for cell_row_cfg (DIMX=64, K=2, PORT_WIDTH=32).
// Expected outputs come from hand-computed vectors and an independent LUT model.
module tb_cell_row_cfg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [64:0] in_signal;
    logic        eval_en;
    logic        cfg_start;
    logic        cfg_valid;
    logic [31:0] cfg_data;
    logic        cfg_ready;
    logic        cfg_done;
    logic        busy;
    logic [3:0]  slot_idx;
    logic [63:0] out;

    int checks = 0;
    int failures = 0;

    cell_row_cfg #(.DIMX(64), .K(2), .PORT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_signal(in_signal),
        .eval_en(eval_en), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready), .cfg_done(cfg_done),
        .busy(busy), .slot_idx(slot_idx), .out(out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [64:0] in;
        logic        en;
        logic [63:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [255:0] a,
                                          input logic [64:0] in);
        logic [63:0] r;
        for (int x = 0; x < 64; x++) begin
            r[x] = a[x*4 + 2*int'(in[x+1]) + int'(in[x])];
        end
        return r;
    endfunction

    function automatic logic [255:0] pack(input logic [31:0] w [8]);
        logic [255:0] r;
        for (int s = 0; s < 8; s++) r[s*32 +: 32] = w[s];
        return r;
    endfunction

    function automatic logic [64:0] rnd65();
        return {$urandom, $urandom, $urandom};
    endfunction

    // cyc counts edges from the cfg_start edge up to the one raising cfg_done
    task automatic load(input logic [31:0] w [8], input bit gaps,
                        input bit hold, output int cyc, output int ngap);
        logic [63:0] prev;
        int i;
        prev = out;
        cyc = 1;
        ngap = 0;
        i = 0;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        while (i < 8 && cyc < 200) begin
            cfg_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_data = w[i];
            if (cfg_valid && cfg_ready) i++;
            else ngap++;
            tick();
            cyc++;
            if (cfg_done) chk("early_done", 64'(cfg_done), 64'd0);
            if (hold) chk("hold_during_load", out, prev);
        end
        cfg_valid = 1'b0;
        while (!cfg_done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("done_seen", 64'(cfg_done), 64'd1);
        if (hold) chk("old_cfg_at_commit", out, prev);
        tick();
        chk("done_one_pulse", 64'(cfg_done), 64'd0);
    endtask

    logic [31:0]  wa [8];
    logic [31:0]  wb [8];
    logic [255:0] mact;
    logic [64:0]  pats [4];
    vec_t         tv [8];
    int           cyc;
    int           ng;
    logic [63:0]  prev;

    initial begin
        tv[0] = '{65'h0, 1'b1, 64'h0};
        tv[1] = '{{65{1'b1}}, 1'b1, {64{1'b1}}};
        tv[2] = '{65'h1, 1'b1, 64'h0};
        tv[3] = '{65'h3, 1'b1, 64'h1};
        tv[4] = '{65'h1_8000_0000_0000_0000, 1'b1, 64'h8000_0000_0000_0000};
        tv[5] = '{65'h0_5555_5555_5555_5555, 1'b1, 64'h0};
        tv[6] = '{{65{1'b1}}, 1'b0, 64'h0};
        tv[7] = '{{65{1'b1}}, 1'b1, {64{1'b1}}};
        pats[0] = 65'h0;
        pats[1] = {65{1'b1}};
        pats[2] = 65'h0_5555_5555_5555_5555;
        pats[3] = 65'h1_AAAA_AAAA_AAAA_AAAA;

        rst_n = 1'b0;
        in_signal = '0;
        eval_en = 1'b0;
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        cfg_data = '0;
        #1;
        chk("rst_out", out, 64'h0);
        chk("rst_done", 64'(cfg_done), 64'd0);
        chk("rst_ready", 64'(cfg_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_slot", 64'(slot_idx), 64'd0);
        #20;
        rst_n = 1'b1;
        tick();
        eval_en = 1'b1;
        in_signal = rnd65();
        tick();
        chk("post_rst_eval", out, 64'h0);

        // full all-ones load: cfg_done 10 cycles after cfg_start
        for (int s = 0; s < 8; s++) wa[s] = 32'hFFFF_FFFF;
        load(wa, 1'b0, 1'b1, cyc, ng);
        chk("ones_latency", 64'(cyc), 64'd10);
        chk("ones_out", out, {64{1'b1}});
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_slot", 64'(slot_idx), 64'd8);

        // AND genome, table vectors
        for (int s = 0; s < 8; s++) wa[s] = 32'h8888_8888;
        load(wa, 1'b0, 1'b0, cyc, ng);
        for (int v = 0; v < 8; v++) begin
            in_signal = tv[v].in;
            eval_en = tv[v].en;
            tick();
            chk($sformatf("and_vec%0d", v), out, tv[v].exp);
        end

        // XOR genome with random inputs
        for (int s = 0; s < 8; s++) wa[s] = 32'h6666_6666;
        load(wa, 1'b0, 1'b0, cyc, ng);
        for (int n = 0; n < 1000; n++) begin
            logic [64:0] r;
            r = rnd65();
            in_signal = r;
            tick();
            chk("xor_eval", out, r[63:0] ^ r[64:1]);
        end

        // backpressure vs gap-free load of the same random genome
        for (int s = 0; s < 8; s++) wa[s] = $urandom;
        mact = pack(wa);
        in_signal = rnd65();
        tick();
        load(wa, 1'b0, 1'b1, cyc, ng);
        chk("nogap_latency", 64'(cyc), 64'd10);
        for (int p = 0; p < 4; p++) begin
            in_signal = pats[p];
            tick();
            chk("nogap_contents", out, model(mact, pats[p]));
        end
        for (int s = 0; s < 8; s++) wb[s] = 32'h6666_6666;
        load(wb, 1'b0, 1'b0, cyc, ng);
        in_signal = rnd65();
        tick();
        load(wa, 1'b1, 1'b1, cyc, ng);
        chk("gap_latency", 64'(cyc), 64'(10 + ng));
        for (int p = 0; p < 4; p++) begin
            in_signal = pats[p];
            tick();
            chk("gap_contents", out, model(mact, pats[p]));
        end

        // restart after 5 words; restart-cycle word discarded
        for (int s = 0; s < 8; s++) begin
            wa[s] = $urandom;
            wb[s] = $urandom;
        end
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        for (int s = 0; s < 5; s++) begin
            cfg_data = wa[s];
            tick();
        end
        chk("pre_restart_slot", 64'(slot_idx), 64'd5);
        cfg_start = 1'b1;
        cfg_data = 32'hDEAD_BEEF;
        #1;
        chk("restart_ready", 64'(cfg_ready), 64'd1);
        tick();
        cfg_start = 1'b0;
        chk("restart_slot", 64'(slot_idx), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        for (int s = 0; s < 8; s++) begin
            cfg_data = wb[s];
            tick();
        end
        cfg_valid = 1'b0;
        chk("restart_commit_busy", 64'(busy), 64'd1);
        tick();
        chk("restart_done", 64'(cfg_done), 64'd1);
        mact = pack(wb);
        for (int p = 0; p < 4; p++) begin
            in_signal = pats[p];
            tick();
            chk("restart_contents", out, model(mact, pats[p]));
        end

        // eval_en low holds out through the load
        eval_en = 1'b0;
        prev = out;
        for (int s = 0; s < 8; s++) wa[s] = $urandom;
        mact = pack(wa);
        in_signal = rnd65();
        load(wa, 1'b0, 1'b1, cyc, ng);
        chk("hold_after_done", out, prev);
        eval_en = 1'b1;
        tick();
        chk("first_eval_new", out, model(mact, in_signal));

        // reset mid-load clears everything immediately
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b1;
        cfg_data = 32'h1234_5678;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_out", out, 64'h0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_ready", 64'(cfg_ready), 64'd0);
        chk("midrst_slot", 64'(slot_idx), 64'd0);
        cfg_valid = 1'b0;
        #10;
        rst_n = 1'b1;
        in_signal = pats[1];
        tick();
        chk("midrst_active_zero", out, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
